// File: rtl/icg_ctrl_multi.sv
// Multi-channel clock-gating controller: per-channel RUN/OFF/WAKE sequencing with
// idle auto-gating, software enable and a req/ack wake handshake, driving latch-based ICGs.
module icg_ctrl_multi #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic             ck_in,
  input  logic             rst_n,
  input  logic             test,
  input  logic [NCH-1:0]   ch_en,
  input  logic [NCH-1:0]   ch_idle,
  input  logic [CNT_W-1:0] idle_thr,
  input  logic [NCH-1:0]   wake_req,
  output logic [NCH-1:0]   wake_ack,
  output logic [NCH-1:0]   ck_out,
  output logic [NCH-1:0]   ch_gated
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } state_e;

  localparam logic [CNT_W:0]   WAKE_LIM = (CNT_W+1)'(WAKE_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             gate_en_q, gate_en_d;
    logic             gated_q, gated_d;
    logic             ack_q, ack_d;
    logic             en_prev_q;
    logic             gate_lat;

    assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign cnt_sat = cnt_inc[CNT_W] ? CNT_MAX : cnt_inc[CNT_W-1:0];

    // Next-state logic; priority is ch_en=0 over wake over idle in every state.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
        ST_RUN: begin
          if (!ch_en[g]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (wake_req[g] || !ch_idle[g]) begin
            cnt_d = '0;
          end else if (idle_thr != '0) begin
            // >= so a threshold lowered below the running count gates on the next idle cycle
            if (cnt_sat >= idle_thr) begin
              state_d = ST_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_sat;
            end
          end
        end
        ST_OFF: begin
          if (ch_en[g] && (wake_req[g] || !en_prev_q)) begin
            state_d = ST_WAKE;
            cnt_d   = '0;
          end
        end
        ST_WAKE: begin
          if (!ch_en[g]) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else if (cnt_inc >= WAKE_LIM) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
      gate_en_d = (state_d != ST_OFF);
      gated_d   = (state_d == ST_OFF);
      ack_d     = (state_d == ST_RUN) && wake_req[g] && ch_en[g];
    end

    always_ff @(posedge ck_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_RUN;
        cnt_q     <= '0;
        gate_en_q <= 1'b1;
        gated_q   <= 1'b0;
        ack_q     <= 1'b0;
        en_prev_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        gate_en_q <= gate_en_d;
        gated_q   <= gated_d;
        ack_q     <= ack_d;
        en_prev_q <= ch_en[g];
      end
    end

    // Gating latch, transparent in the low phase so enable changes land only at a rising edge.
    always_latch begin
      if (!ck_in) gate_lat = gate_en_q | test;
    end

    assign ck_out[g]   = ck_in & gate_lat;
    assign ch_gated[g] = gated_q;
    assign wake_ack[g] = ack_q;
  end

endmodule

// File: tb/tb_icg_ctrl_multi.sv
// Directed, table-driven bench for icg_ctrl_multi: one vector per clock, expected
// gating/ack state hand-computed, ck_out checked in both clock phases.
module tb_icg_ctrl_multi;

  localparam int unsigned NCH      = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned WAKE_CYC = 2;

  logic             ck_in;
  logic             rst_n;
  logic             test;
  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   ch_idle;
  logic [CNT_W-1:0] idle_thr;
  logic [NCH-1:0]   wake_req;
  logic [NCH-1:0]   wake_ack;
  logic [NCH-1:0]   ck_out;
  logic [NCH-1:0]   ch_gated;

  icg_ctrl_multi #(.NCH(NCH), .CNT_W(CNT_W), .WAKE_CYC(WAKE_CYC)) dut (
    .ck_in    (ck_in),
    .rst_n    (rst_n),
    .test     (test),
    .ch_en    (ch_en),
    .ch_idle  (ch_idle),
    .idle_thr (idle_thr),
    .wake_req (wake_req),
    .wake_ack (wake_ack),
    .ck_out   (ck_out),
    .ch_gated (ch_gated)
  );

  initial ck_in = 1'b0;
  always #5 ck_in = ~ck_in;

  typedef struct {
    logic [NCH-1:0]   en;
    logic [NCH-1:0]   idle;
    logic [NCH-1:0]   wreq;
    logic [CNT_W-1:0] thr;
    logic             tst;
    logic [NCH-1:0]   gated;
    logic [NCH-1:0]   ack;
  } vec_t;

  vec_t           vecs[$];
  int             checks;
  int             errors;
  logic [NCH-1:0] prev_gated;

  function automatic void add(input logic [NCH-1:0] en, input logic [NCH-1:0] idle,
                              input logic [NCH-1:0] wreq, input logic [CNT_W-1:0] thr,
                              input logic tst, input logic [NCH-1:0] gated,
                              input logic [NCH-1:0] ack);
    vec_t v;
    v.en = en; v.idle = idle; v.wreq = wreq; v.thr = thr;
    v.tst = tst; v.gated = gated; v.ack = ack;
    vecs.push_back(v);
  endfunction

  task automatic check(input string nm, input int row, input logic [NCH-1:0] got,
                       input logic [NCH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h exp %h", nm, row, got, exp);
    end
  endtask

  // ck_out at a rising edge reflects the gate state set up before that edge.
  task automatic step(input vec_t v, input int row);
    ch_en    = v.en;
    ch_idle  = v.idle;
    wake_req = v.wreq;
    idle_thr = v.thr;
    test     = v.tst;
    @(posedge ck_in);
    #1;
    check("ch_gated", row, ch_gated, v.gated);
    check("wake_ack", row, wake_ack, v.ack);
    check("ck_out_hi", row, ck_out, ~prev_gated | {NCH{v.tst}});
    prev_gated = v.gated;
    @(negedge ck_in);
    #1;
    check("ck_out_lo", row, ck_out, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t post;
    checks     = 0;
    errors     = 0;
    prev_gated = '0;

    //   en       idle     wreq     thr    tst   gated    ack
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0000, 4'b0000); // 1
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0001, 4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000); // 4: ch0 gates
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000);
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000);
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0001, 4'b0000);
    add(4'b1111, 4'b0011, 4'b0000, 8'd4, 1'b0, 4'b0011, 4'b0000); // 8: ch1 gates
    add(4'b1111, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0011, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0001, 8'd4, 1'b0, 4'b0010, 4'b0000); // 10: ch0 wake
    add(4'b1111, 4'b0000, 4'b0001, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0001, 8'd4, 1'b0, 4'b0010, 4'b0001); // 12: ack
    add(4'b1111, 4'b0000, 4'b0001, 8'd4, 1'b0, 4'b0010, 4'b0001);
    add(4'b1111, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1011, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0110, 4'b0000); // 15: ch2 disabled
    add(4'b1111, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000); // ch_en rise -> WAKE
    add(4'b1011, 4'b0000, 4'b0100, 8'd4, 1'b0, 4'b0110, 4'b0000); // disabled mid-WAKE
    add(4'b1111, 4'b0000, 4'b0100, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0100, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b0000, 4'b0100, 8'd4, 1'b0, 4'b0010, 4'b0100); // 20
    add(4'b1111, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b0000, 4'b1000, 8'd4, 1'b0, 4'b0010, 4'b1000); // req in RUN
    add(4'b1111, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b1000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b1000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b1000, 4'b0000, 8'd4, 1'b0, 4'b0010, 4'b0000);
    add(4'b1111, 4'b1000, 4'b0000, 8'd2, 1'b0, 4'b1010, 4'b0000); // 27: lowered thr
    add(4'b1010, 4'b0000, 4'b0000, 8'd2, 1'b0, 4'b1111, 4'b0000);
    add(4'b1010, 4'b0000, 4'b0000, 8'd2, 1'b1, 4'b1111, 4'b0000); // test override
    add(4'b1010, 4'b0000, 4'b0000, 8'd2, 1'b1, 4'b1111, 4'b0000);
    add(4'b1010, 4'b0000, 4'b0000, 8'd2, 1'b0, 4'b1111, 4'b0000);
    add(4'b1010, 4'b0000, 4'b0000, 8'd2, 1'b0, 4'b1111, 4'b0000);
    add(4'b1111, 4'b0000, 4'b1010, 8'd2, 1'b0, 4'b0000, 4'b0000); // 33: all wake
    add(4'b1111, 4'b0000, 4'b1010, 8'd2, 1'b0, 4'b0000, 4'b0000);
    add(4'b1111, 4'b0000, 4'b1010, 8'd2, 1'b0, 4'b0000, 4'b1010);
    add(4'b1111, 4'b0000, 4'b0000, 8'd2, 1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 300; i++)
      add(4'b1111, 4'b1111, 4'b0000, 8'd0, 1'b0, 4'b0000, 4'b0000);
    add(4'b0110, 4'b0000, 4'b0000, 8'd4, 1'b0, 4'b1001, 4'b0000);
    add(4'b0111, 4'b0000, 4'b0010, 8'd4, 1'b0, 4'b1000, 4'b0010); // ch0 in WAKE

    rst_n    = 1'b1;
    test     = 1'b0;
    ch_en    = '1;
    ch_idle  = '0;
    wake_req = '0;
    idle_thr = 8'd4;
    #1 rst_n = 1'b0;
    @(posedge ck_in);
    #1;
    check("rst_gated", 0, ch_gated, '0);
    check("rst_ack", 0, wake_ack, '0);
    check("rst_ck_out", 0, ck_out, '1);
    @(negedge ck_in);
    #1 rst_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) step(vecs[r], r + 1);

    // Asynchronous reset while ch0 is mid-WAKE, ch1 acked and ch3 gated.
    rst_n = 1'b0;
    #1;
    check("async_rst_gated", 0, ch_gated, '0);
    check("async_rst_ack", 0, wake_ack, '0);
    @(posedge ck_in);
    #1;
    check("async_rst_ck_out", 0, ck_out, '1);
    @(negedge ck_in);
    #1 rst_n = 1'b1;
    prev_gated = '0;
    post.en = 4'b1111; post.idle = 4'b0000; post.wreq = 4'b0000; post.thr = 8'd4;
    post.tst = 1'b0; post.gated = 4'b0000; post.ack = 4'b0000;
    step(post, 999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
